scoreboard_hazard_unit: RTL and testbench

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/scoreboard_hazard_unit.sv | 138 +++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
//   Per-register pending counters that detect RAW hazards for the ID stage.
//   When a producer issues, its destination counter is loaded with the number
//   of cycles a dependent instruction must wait. The load value depends on
//   the forwarding mode and on whether the producer is a load. A source
//   register is pending while its counter is nonzero. Counters hold while
//   the pipeline is frozen.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset (clears all counters)
//   id_valid          a valid instruction is in ID
//   src1, src2        ID source register indices (src2 used only if two_src)
//   two_src           src2 is read
//   id_dest           ID destination register
//   id_wb_en          ID instruction writes id_dest
//   id_mem_r_en       ID instruction is a load
//   is_forwarding     forwarding mode select
//   flush             kill the ID instruction (no issue)
//   freeze            pipeline frozen: counters hold, no issue
//   hazard_detection  stall IF/ID this cycle (combinational)
//   busy_vec          bit r set while register r is pending
//   stall_cycles      (HAZARD_PERF_CNT_EN) saturating count of stalled, unfrozen cycles
//   hazard_events     (HAZARD_PERF_CNT_EN) saturating count of hazard rising edges
//
// Optional feature macro: HAZARD_PERF_CNT_EN
module scoreboard_hazard_unit #(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int MEM_LAT  = 1,
  parameter int WB_LAT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    src1,
  input  logic [REG_W-1:0]    src2,
  input  logic                two_src,
  input  logic [REG_W-1:0]    id_dest,
  input  logic                id_wb_en,
  input  logic                id_mem_r_en,
  input  logic                is_forwarding,
  input  logic                flush,
  input  logic                freeze,
  output logic                hazard_detection,
  output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [15:0]         hazard_events
`endif
);

  localparam int MAX_LAT = (MEM_LAT > WB_LAT) ? MEM_LAT : WB_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  logic             w_pend1;
  logic             w_pend2;
  logic             w_issue;
  logic [CNT_W-1:0] w_load;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : (c - 1'b1);
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Sources are checked against registered counters only, so an instruction
  // whose destination equals one of its own sources never stalls on itself.
  assign w_pend1 = (r_cnt[src1] != '0);
  assign w_pend2 = two_src && (r_cnt[src2] != '0);

  // Gated by rst so a reset mid-stall releases ID in the same cycle.
  assign hazard_detection = !rst && id_valid && (w_pend1 || w_pend2);

  assign w_issue = id_valid && !hazard_detection && !flush && !freeze;

  always_comb begin
    w_load = '0;
    if (!is_forwarding) begin
      w_load = CNT_W'(WB_LAT);
    end else if (id_mem_r_en) begin
      w_load = CNT_W'(MEM_LAT);
    end
  end

  // Counter update stage: decrement every cycle unless frozen; the issuing
  // destination keeps the larger of its decremented value and the new load
  // value so an older, longer-latency producer is never shortened.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else if (!freeze) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_issue && id_wb_en && (id_dest == REG_W'(r))) begin
          r_cnt[r] <= max_cnt(sat_dec(r_cnt[r]), w_load);
        end else begin
          r_cnt[r] <= sat_dec(r_cnt[r]);
        end
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (r_cnt[r] != '0);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic r_haz_prev;

  // Performance counter stage: both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      hazard_events <= '0;
      r_haz_prev    <= 1'b0;
    end else begin
      r_haz_prev <= hazard_detection;
      if (hazard_detection && !freeze && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (hazard_detection && !r_haz_prev && (hazard_events != '1)) begin
        hazard_events <= hazard_events + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
module tb_scoreboard_hazard_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic [3:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_r_en;
  logic        is_forwarding;
  logic        flush;
  logic        freeze;
  logic        hazard_detection;
  logic [15:0] busy_vec;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] hazard_events;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        v;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        two;
    logic [3:0]  d;
    logic        wb;
    logic        ld;
    logic        fwd;
    logic        fl;
    logic        fz;
    logic        rs;
    logic        eh;
    logic [15:0] eb;
  } step_t;

  typedef struct packed {
    logic        h;
    logic [15:0] b;
  } exp_t;

  step_t stim_q[$];
  exp_t  exp_q[$];

  scoreboard_hazard_unit #(
    .NUM_REGS(16),
    .MEM_LAT (1),
    .WB_LAT  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .src1             (src1),
    .src2             (src2),
    .two_src          (two_src),
    .id_dest          (id_dest),
    .id_wb_en         (id_wb_en),
    .id_mem_r_en      (id_mem_r_en),
    .is_forwarding    (is_forwarding),
    .flush            (flush),
    .freeze           (freeze),
    .hazard_detection (hazard_detection),
    .busy_vec         (busy_vec)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .hazard_events    (hazard_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(input int v, input int s1, input int s2, input int two,
                               input int d, input int wb, input int ld, input int fwd,
                               input int fl, input int fz, input int rs, input int eh,
                               input logic [15:0] eb);
    step_t s;
    s.v   = (v != 0);
    s.s1  = 4'(s1);
    s.s2  = 4'(s2);
    s.two = (two != 0);
    s.d   = 4'(d);
    s.wb  = (wb != 0);
    s.ld  = (ld != 0);
    s.fwd = (fwd != 0);
    s.fl  = (fl != 0);
    s.fz  = (fz != 0);
    s.rs  = (rs != 0);
    s.eh  = (eh != 0);
    s.eb  = eb;
    return s;
  endfunction

  function automatic step_t idl(input int fz, input logic [15:0] eb);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, fz, 0, 0, eb);
  endfunction

  task automatic apply(input step_t s);
    id_valid      = s.v;
    src1          = s.s1;
    src2          = s.s2;
    two_src       = s.two;
    id_dest       = s.d;
    id_wb_en      = s.wb;
    id_mem_r_en   = s.ld;
    is_forwarding = s.fwd;
    flush         = s.fl;
    freeze        = s.fz;
    rst           = s.rs;
  endtask

  task automatic test_reset();
    step_t s;
    exp_t  e;
    int    n = 0;
    apply(mk(1, 3, 3, 1, 3, 1, 1, 1, 0, 0, 1, 0, 16'h0000));
    repeat (2) @(posedge clk);
    #1;
    stim_q.push_back(mk(1, 3, 3, 1, 3, 1, 1, 1, 0, 0, 1, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL reset step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0 || hazard_events !== 16'd0) begin
      errors++;
      $display("FAIL reset_perf stall=%0d events=%0d expected 0 0", stall_cycles, hazard_events);
    end
`endif
  endtask

  task automatic test_load_use();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 3, 0, 0, 6, 1, 0, 1, 0, 0, 0, 1, 16'h0008));
    stim_q.push_back(mk(1, 3, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL load_use step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fwd_no_stall();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 5, 5, 1, 7, 1, 0, 1, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL fwd_no_stall step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wb_lat();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 1, 16'h0002));
    stim_q.push_back(mk(1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 1, 16'h0002));
    stim_q.push_back(mk(1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0080));
    stim_q.push_back(idl(0, 16'h0080));
    stim_q.push_back(idl(0, 16'h0000));
    stim_q.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0002));
    stim_q.push_back(idl(0, 16'h0002));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL wb_lat step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_freeze();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(1, 16'h0004));
    stim_q.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 16'h0004));
    stim_q.push_back(mk(1, 0, 0, 0, 9, 1, 1, 1, 0, 1, 0, 0, 16'h0004));
    stim_q.push_back(idl(0, 16'h0004));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL freeze step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_flush_reset();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0000));
    stim_q.push_back(mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 0, 0, 0, 6, 1, 1, 0, 1, 0, 0, 0, 16'h0020));
    stim_q.push_back(idl(0, 16'h0020));
    stim_q.push_back(idl(0, 16'h0000));
    stim_q.push_back(mk(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0100));
    stim_q.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0100));
    stim_q.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL flush_reset step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mode_switch();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0400));
    stim_q.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0400));
    stim_q.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL mode_switch step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_self_dep();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 11, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 11, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1, 16'h0800));
    stim_q.push_back(mk(1, 11, 0, 0, 11, 1, 0, 0, 0, 0, 0, 1, 16'h0800));
    stim_q.push_back(mk(1, 11, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0800));
    stim_q.push_back(idl(0, 16'h0800));
    stim_q.push_back(idl(0, 16'h0000));
    stim_q.push_back(mk(1, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 0, 0, 0, 12, 1, 0, 1, 0, 0, 0, 0, 16'h1000));
    stim_q.push_back(idl(0, 16'h1000));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL self_dep step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(1, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(mk(1, 0, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 16'h0008));
    stim_q.push_back(mk(1, 3, 4, 1, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0010));
    stim_q.push_back(mk(1, 3, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000));
    stim_q.push_back(idl(0, 16'h0000));
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL back_to_back step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    step_t s;
    exp_t  e;
    int    n = 0;
    stim_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h0000));
    for (int k = 0; k < 2; k++) begin
      stim_q.push_back(mk(1, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 16'h0000));
      stim_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0008));
      stim_q.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000));
      stim_q.push_back(idl(0, 16'h0000));
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      apply(s);
      exp_q.push_back({s.eh, s.eb});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({hazard_detection, busy_vec} !== {e.h, e.b}) begin
        errors++;
        $display("FAIL perf step%0d haz=%b busy=%h expected haz=%b busy=%h",
                 n, hazard_detection, busy_vec, e.h, e.b);
      end
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++;
      $display("FAIL perf_stall_cycles got=%0d expected=2", stall_cycles);
    end
    checks++;
    if (hazard_events !== 16'd2) begin
      errors++;
      $display("FAIL perf_hazard_events got=%0d expected=2", hazard_events);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_fwd_no_stall();
    test_wb_lat();
    test_freeze();
    test_flush_reset();
    test_mode_switch();
    test_self_dep();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
